// File: rtl/mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmio_arbiter
// Description : Two-master arbiter for the shared MMIO data bus. M0 is the
//               CPU load/store port and M1 is the DMA/serial loader.
//               Arbitration is round-robin. M1 may hold bounded locked
//               bursts, and a starvation guard protects M0. Read data
//               returns one cycle after the grant and is tagged to the
//               master that issued the read.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        bus_re,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] c_max_burst    = 8'(MAX_BURST);
  localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;          // 1 = M1 was granted most recently
  logic [7:0]  r_burst_cnt;
  logic [7:0]  w_burst_cnt_nxt;
  logic [7:0]  r_starve_cnt;
  logic        r_rtag_v;
  logic        r_rtag_id;       // 1 = read belongs to M1
  logic        w_arb_g0;
  logic        w_arb_g1;
  logic        w_force_m0;
  logic        w_burst_hold;

  // M0 is forced only while it is actually asking; a withdrawn request
  // leaves the normal rules in charge.
  assign w_force_m0   = m0_req & (r_starve_cnt == c_starve_limit);
  assign w_burst_hold = (r_state == ST_BURST) & m1_lock &
                        (r_burst_cnt < c_max_burst) & ~w_force_m0;

  // Winner selection and next FSM state / burst count.
  always_comb begin
    w_arb_g0        = 1'b0;
    w_arb_g1        = 1'b0;
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    if (w_burst_hold) begin
      // Burst continues; an idle M1 cycle lets M0 through without ending it.
      if (m1_req) begin
        w_arb_g1        = 1'b1;
        w_burst_cnt_nxt = r_burst_cnt + 8'd1;
      end else begin
        w_arb_g0 = m0_req;
      end
    end else begin
      if (w_force_m0) begin
        w_arb_g0 = 1'b1;
      end else if (m0_req && m1_req) begin
        w_arb_g0 = r_last;
        w_arb_g1 = ~r_last;
      end else begin
        w_arb_g0 = m0_req;
        w_arb_g1 = m1_req;
      end
      if (w_arb_g1 && m1_lock) begin
        w_state_nxt     = ST_BURST;
        w_burst_cnt_nxt = 8'd1;
      end else begin
        w_state_nxt     = ST_ARB;
        w_burst_cnt_nxt = 8'd0;
      end
    end
  end

  // Grants are suppressed while reset is asserted so the bus stays quiet.
  assign m0_gnt = w_arb_g0 & rst_n;
  assign m1_gnt = w_arb_g1 & rst_n;

  assign bus_re    = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
  assign bus_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign bus_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : 32'd0);
  assign bus_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : 32'd0);
  assign bus_wmask = m0_gnt ? m0_wmask : (m1_gnt ? m1_wmask : 4'd0);

  assign m0_rvalid = r_rtag_v & ~r_rtag_id;
  assign m1_rvalid = r_rtag_v & r_rtag_id;
  assign m0_rdata  = m0_rvalid ? bus_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? bus_rdata : 32'd0;

  // FSM, round-robin pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ARB;
      r_last      <= 1'b1;
      r_burst_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (m0_gnt) begin
        r_last <= 1'b0;
      end else if (m1_gnt) begin
        r_last <= 1'b1;
      end
    end
  end

  // Saturating count of cycles M0 has waited with its request up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 8'd0;
    end else if (!m0_req || m0_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt != 8'hFF) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Read tag: remembers who owns the data arriving next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rtag_v  <= 1'b0;
      r_rtag_id <= 1'b0;
    end else begin
      r_rtag_v  <= bus_re;
      r_rtag_id <= m1_gnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_arbiter
// Description : Self-checking bench for mmio_arbiter: scripted grant table,
//               directed corner sequences and constrained-random traffic
//               against a behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_arbiter;

  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_re, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;

  mmio_arbiter #(.MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit md_burst;       // M1 holds a locked burst
  bit md_last;        // most recent winner (1 = M1)
  int md_bcnt;        // grants given in the current burst
  int md_wait;        // consecutive cycles M0 waited
  int md_rq[$];       // owners of reads whose data is due next cycle

  // Last sampled DUT outputs
  logic        s_g0, s_g1, s_rv0, s_rv1, s_re, s_we;
  logic [31:0] s_rd0, s_rd1, s_addr, s_wdata;
  logic [3:0]  s_wmask;

  typedef struct packed {
    bit r0, w0, r1, w1, lk, g0, g1;
  } vec_t;
  vec_t tbl[24];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    md_burst = 1'b0;
    md_last  = 1'b1;
    md_bcnt  = 0;
    md_wait  = 0;
    md_rq.delete();
  endfunction

  task automatic check_quiet(string tag);
    chk({tag, "_gnt0"}, 32'(m0_gnt), 0);
    chk({tag, "_gnt1"}, 32'(m1_gnt), 0);
    chk({tag, "_re"}, 32'(bus_re), 0);
    chk({tag, "_we"}, 32'(bus_we), 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_rv0"}, 32'(m0_rvalid), 0);
    chk({tag, "_rv1"}, 32'(m1_rvalid), 0);
    chk({tag, "_rd0"}, m0_rdata, 0);
    chk({tag, "_rd1"}, m1_rdata, 0);
  endtask

  // One bus cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit r0, w0, r1, w1, lk,
                      input logic [31:0] a0, d0, a1, d1,
                      input logic [3:0] k0, k1, input logic [31:0] rd);
    bit force0, hold, e0, e1, erd;
    int resp;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_wmask = k0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_wmask = k1;
    m1_lock = lk; bus_rdata = rd;
    #1;
    force0 = r0 && (md_wait >= STARVE_LIMIT);
    hold   = md_burst && lk && (md_bcnt < MAX_BURST) && !force0;
    e0 = 1'b0; e1 = 1'b0;
    if (hold) begin
      if (r1) e1 = 1'b1; else e0 = r0;
    end else if (force0) e0 = 1'b1;
    else if (r0 && r1) begin
      if (md_last) e0 = 1'b1; else e1 = 1'b1;
    end else begin
      e0 = r0; e1 = r1;
    end
    erd  = (e0 && !w0) || (e1 && !w1);
    resp = (md_rq.size() > 0) ? md_rq[0] : -1;
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_re = bus_re; s_we = bus_we;
    s_addr = bus_addr; s_wdata = bus_wdata; s_wmask = bus_wmask;
    s_rv0 = m0_rvalid; s_rv1 = m1_rvalid; s_rd0 = m0_rdata; s_rd1 = m1_rdata;
    chk("gnt0", 32'(s_g0), 32'(e0));
    chk("gnt1", 32'(s_g1), 32'(e1));
    chk("bus_re", 32'(s_re), 32'(erd));
    chk("bus_we", 32'(s_we), 32'((e0 && w0) || (e1 && w1)));
    chk("bus_addr", s_addr, e0 ? a0 : (e1 ? a1 : 32'd0));
    chk("bus_wdata", s_wdata, e0 ? d0 : (e1 ? d1 : 32'd0));
    chk("bus_wmask", 32'(s_wmask), 32'(e0 ? k0 : (e1 ? k1 : 4'd0)));
    chk("rvalid0", 32'(s_rv0), 32'(resp == 0));
    chk("rvalid1", 32'(s_rv1), 32'(resp == 1));
    chk("rdata0", s_rd0, (resp == 0) ? rd : 32'd0);
    chk("rdata1", s_rd1, (resp == 1) ? rd : 32'd0);
    @(posedge clk);
    md_rq.delete();
    if (erd) md_rq.push_back(e1 ? 1 : 0);
    if (e0) md_last = 1'b0; else if (e1) md_last = 1'b1;
    if (!r0 || e0) md_wait = 0; else if (md_wait < 255) md_wait++;
    if (hold) begin
      if (e1) md_bcnt++;
    end else if (e1 && lk) begin
      md_burst = 1'b1; md_bcnt = 1;
    end else begin
      md_burst = 1'b0; md_bcnt = 0;
    end
  endtask

  task automatic idle(input logic [31:0] rd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd);
  endtask

  bit          p0, p1, pw0, pw1, lk;
  logic [31:0] pa0, pd0, pa1, pd1;
  logic [3:0]  pk0, pk1;

  initial begin
    // Grant script: alternation, full burst, starvation break, idle-M1 burst.
    tbl[0]  = '{1,0,1,0,0, 1,0};
    tbl[1]  = '{1,0,1,0,0, 0,1};
    tbl[2]  = '{1,1,1,0,0, 1,0};
    tbl[3]  = '{1,0,1,1,0, 0,1};
    for (int i = 4; i < 12; i++) tbl[i] = '{0,0,1,0,1, 0,1};
    tbl[12] = '{1,0,1,0,1, 1,0};
    tbl[13] = '{0,0,1,0,1, 0,1};
    for (int i = 14; i < 18; i++) tbl[i] = '{1,0,1,0,1, 0,1};
    tbl[18] = '{1,0,1,0,1, 1,0};
    tbl[19] = '{0,0,1,0,1, 0,1};
    tbl[20] = '{1,0,0,0,1, 1,0};
    tbl[21] = '{1,0,1,0,1, 0,1};
    tbl[22] = '{1,0,1,0,0, 1,0};
    tbl[23] = '{0,0,0,0,0, 0,0};

    // Reset with both masters requesting: everything must stay quiet.
    rst_n = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0010_0000; m0_wdata = 0; m0_wmask = 4'hF;
    m1_req = 1; m1_we = 0; m1_addr = 32'h0020_0000; m1_wdata = 0; m1_wmask = 4'hF;
    m1_lock = 1; bus_rdata = 32'h1234_5678;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_quiet("reset");
    @(negedge clk);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].lk,
           32'h0010_0000 + 32'(i * 4), $urandom, 32'h0050_0000 + 32'(i * 4), $urandom,
           4'hF, 4'h3, $urandom);
      chk($sformatf("tbl%0d_gnt0", i), 32'(s_g0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(s_g1), 32'(tbl[i].g1));
    end

    // M0 read, data returned next cycle.
    step(1, 0, 0, 0, 0, 32'h0010_0004, 0, 0, 0, 4'hF, 0, $urandom);
    chk("rd_gnt0", 32'(s_g0), 1);
    chk("rd_re", 32'(s_re), 1);
    idle(32'hDEAD_BEEF);
    chk("rd_rvalid0", 32'(s_rv0), 1);
    chk("rd_rdata0", s_rd0, 32'hDEAD_BEEF);
    chk("rd_rvalid1", 32'(s_rv1), 0);

    // M0 write then M1 read back-to-back.
    step(1, 1, 0, 0, 0, 32'h0070_0000, 32'h0000_00FF, 0, 0, 4'b0001, 0, $urandom);
    chk("wr_we", 32'(s_we), 1);
    chk("wr_addr", s_addr, 32'h0070_0000);
    chk("wr_wdata", s_wdata, 32'h0000_00FF);
    chk("wr_wmask", 32'(s_wmask), 32'h1);
    step(0, 0, 1, 0, 0, 0, 0, 32'h0020_0008, 0, 0, 4'hF, $urandom);
    chk("m1rd_re", 32'(s_re), 1);
    chk("m1rd_addr", s_addr, 32'h0020_0008);
    chk("m1rd_rv0", 32'(s_rv0), 0);
    idle(32'hCAFE_0001);
    chk("m1rd_rvalid1", 32'(s_rv1), 1);
    chk("m1rd_rdata1", s_rd1, 32'hCAFE_0001);
    chk("m1rd_rvalid0", 32'(s_rv0), 0);

    // Reset in the cycle after an M1 read grant.
    step(0, 0, 1, 0, 1, 0, 0, 32'h0030_0000, 0, 0, 4'hF, $urandom);
    @(negedge clk);
    rst_n = 1'b0;
    m0_req = 1; m1_req = 1; m1_lock = 1; bus_rdata = 32'hFFFF_FFFF;
    #1 check_quiet("midrst_a");
    @(negedge clk);
    #1 check_quiet("midrst_b");
    @(negedge clk);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 1, 0, 1, 32'h0040_0000, 0, 32'h0050_0000, 0, 4'hF, 4'hF, $urandom);
    chk("postrst_gnt0", 32'(s_g0), 1);
    chk("postrst_rv1", 32'(s_rv1), 0);

    // Random traffic; requests and payloads are held until granted.
    p0 = s_g0 ? 1'b0 : 1'b1;
    p1 = s_g1 ? 1'b0 : 1'b1;
    pw0 = 0; pw1 = 0; pa0 = 32'h0040_0000; pa1 = 32'h0050_0000;
    pd0 = 0; pd1 = 0; pk0 = 4'hF; pk1 = 4'hF;
    for (int c = 0; c < 600; c++) begin
      if (!p0 && ($urandom_range(0, 2) != 0)) begin
        p0 = 1; pw0 = 1'($urandom); pa0 = $urandom; pd0 = $urandom; pk0 = 4'($urandom);
      end
      if (!p1 && ($urandom_range(0, 3) != 0)) begin
        p1 = 1; pw1 = 1'($urandom); pa1 = $urandom; pd1 = $urandom; pk1 = 4'($urandom);
      end
      lk = ($urandom_range(0, 4) != 0);
      step(p0, pw0, p1, pw1, lk, pa0, pd0, pa1, pd1, pk0, pk1, $urandom);
      if (s_g0) p0 = 0;
      if (s_g1) p1 = 0;
    end
    idle($urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter in front of the memory-mapped I/O decoder. It shares the single data bus, which reaches data memory, keyboard, timer, switches, seven-segment display, character memory, frame buffer, VGA mode register, LEDs and serial, between the CPU load/store port (M0) and a DMA/serial-loader port (M1). It uses round-robin arbitration, bounded locked bursts for M1 and a starvation guard. Read data returns on the following cycle, tagged to the master that issued the read.

## Interface
- `MAX_BURST`, default 8: maximum consecutive M1 grants while `m1_lock` is held. Range 1..255.
- `STARVE_LIMIT`, default 4: number of consecutive cycles M0 may wait while requesting before M0 gets forced priority. Range 1..255.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1: access request. Held, together with its payload, until the matching `mX_gnt`.
- `m0_we`, `m1_we` in 1: 1 selects write, 0 selects read.
- `m0_addr`, `m1_addr` in 32: byte address. The decoder uses bits [23:20].
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_wmask`, `m1_wmask` in 4: byte enables.
- `m1_lock` in 1: M1 requests back-to-back grants (burst).
- `m0_gnt`, `m1_gnt` out 1: combinational. The request is accepted this cycle.
- `m0_rvalid`, `m1_rvalid` out 1: registered. Read data is valid this cycle.
- `m0_rdata`, `m1_rdata` out 32: equal to `bus_rdata` when the matching rvalid is 1, otherwise 0.
- `bus_re`, `bus_we` out 1: access strobes to the decoder/memory.
- `bus_addr` out 32, `bus_wdata` out 32, `bus_wmask` out 4: muxed payload.
- `bus_rdata` in 32: decoder read data, valid one cycle after a `bus_re` cycle.

## Operation
- At most one grant per cycle. `bus_*` carries the winner's payload.
  - `bus_re = gnt & ~we`; `bus_we = gnt & we`.
  - With no grant, `bus_addr`, `bus_wdata` and `bus_wmask` are 0.
- State machine: ARB and BURST.
- In ARB:
  - Only one master requesting: that master wins.
  - Both requesting: the winner is the master that is not `last`, the master granted most recently.
  - `starve_cnt == STARVE_LIMIT`: M0 wins regardless of `last`.
  - An M1 grant with `m1_lock=1` moves the FSM to BURST with `burst_cnt=1`.
- In BURST:
  - M1 wins whenever `m1_req=1`, `m1_lock=1` and `burst_cnt < MAX_BURST`. Each such grant increments `burst_cnt`.
  - The FSM returns to ARB when `m1_lock=0`, when `burst_cnt == MAX_BURST`, or when the starvation limit is hit. That cycle is then arbitrated by the ARB rules, so a forced M0 wins immediately.
  - If `m1_req=0` while `m1_lock=1`, the FSM stays in BURST, no grant is given to M1, and M0 may be granted. `burst_cnt` is unchanged.
- `last` is updated on every grant.
- `starve_cnt` (8 bits, saturating):
  - increments each cycle in which `m0_req=1` and `m0_gnt=0`;
  - clears on an `m0_gnt` or when `m0_req=0`.
- Read return:
  - Register `rtag_v` (1 bit) and `rtag_id` capture `bus_re` and the winner.
  - Next cycle, `mX_rvalid = rtag_v & (rtag_id==X)` and `mX_rdata = bus_rdata`.
  - Writes produce no response.
- Arithmetic: `burst_cnt` is 8 bits and is compared unsigned against `MAX_BURST`. Neither counter ever wraps.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - state ARB, `last`=M1 (so M0 wins first contention), `burst_cnt`=0, `starve_cnt`=0, `rtag_v`=0;
  - all `gnt`, `rvalid`, `bus_re` and `bus_we` = 0; `rdata` = 0.
- Grant latency: 0 cycles. `mX_gnt` is combinational from the requests and the registered state.
- Read latency: `mX_rvalid` is asserted exactly 1 cycle after the grant cycle, for one cycle.
- Throughput: one access per cycle. Reads and writes may be granted back-to-back. A read response and a new grant may coincide.
- Reset mid-operation:
  - a pending `rtag_v` is discarded, so no rvalid appears after reset;
  - an in-progress burst is abandoned.
- A request withdrawn without a grant is ignored. This is a protocol violation and must not corrupt state.

## Test plan
- Reset release, `m0_req=1` read at `0x0010_0004`, `bus_rdata=0xDEADBEEF` next cycle -> `m0_gnt=1` in cycle 0; `m0_rvalid=1` and `m0_rdata=0xDEADBEEF` in cycle 1; `m1_rvalid=0` throughout.
- Both masters request continuously with no lock -> grants alternate M0, M1, M0, M1…; the first grant goes to M0.
- M1 holds `m1_lock=1` and `m1_req=1`, `MAX_BURST=8`, M0 idle -> 8 consecutive `m1_gnt`. On the 9th cycle the FSM returns to ARB and M1 is granted again only if M0 is not requesting.
- M1 burst with `STARVE_LIMIT=4`, M0 requesting from the burst's second cycle -> M0 is granted on the cycle after `starve_cnt` reaches 4. `burst_cnt` resets and `starve_cnt` clears to 0.
- M0 write to `0x0070_0000`, data `0x000000FF`, mask `4'b0001`, followed in the next cycle by an M1 read -> `bus_we=1` with the M0 payload, then `bus_re=1` with `m1_addr`. Only `m1_rvalid` fires, 1 cycle later.
- Assert `rst_n=0` in the cycle after an M1 read grant -> `m1_rvalid` stays 0 and all outputs are 0 during reset. After release, M0 wins the first contention.
